// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  // Bit index counter width for a WIDTH-bit scan.
  function automatic int idx_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/comparator.sv
// 1-bit magnitude comparator cell; purely combinational.
module comparator (
  input  logic A,
  input  logic B,
  output logic A_greater_B,
  output logic A_equal_B,
  output logic A_lesser_B
);

  assign A_greater_B = A & ~B;
  assign A_equal_B   = ~(A ^ B);
  assign A_lesser_B  = ~A & B;

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator: scans MSB first through one
// 1-bit cell and stops at the first differing bit.
module serial_mag_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             A_greater_B,
  output logic             A_equal_B,
  output logic             A_lesser_B
);

  localparam int IDX_W = idx_width(WIDTH);

  cmp_state_t       state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [IDX_W-1:0] idx_r;
  logic             cell_gt_s;
  logic             cell_eq_s;
  logic             cell_lt_s;

  comparator u_cell (
    .A           (a_sh_r[WIDTH-1]),
    .B           (b_sh_r[WIDTH-1]),
    .A_greater_B (cell_gt_s),
    .A_equal_B   (cell_eq_s),
    .A_lesser_B  (cell_lt_s)
  );

  // Control FSM with shift registers, bit index and registered status/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_sh_r      <= {WIDTH{1'b0}};
      b_sh_r      <= {WIDTH{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      A_greater_B <= 1'b0;
      A_equal_B   <= 1'b0;
      A_lesser_B  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= SCAN;
            a_sh_r      <= A;
            b_sh_r      <= B;
            idx_r       <= IDX_W'(WIDTH - 1);
            ready       <= 1'b0;
            busy        <= 1'b1;
            A_greater_B <= 1'b0;
            A_equal_B   <= 1'b0;
            A_lesser_B  <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        SCAN: begin
          if (!cell_eq_s) begin
            state_r     <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            A_greater_B <= cell_gt_s;
            A_lesser_B  <= cell_lt_s;
          end else if (idx_r == {IDX_W{1'b0}}) begin
            state_r   <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            A_equal_B <= 1'b1;
          end else begin
            // Exit at idx==0 above guarantees this decrement never wraps.
            a_sh_r <= {a_sh_r[WIDTH-2:0], 1'b0};
            b_sh_r <= {b_sh_r[WIDTH-2:0], 1'b0};
            idx_r  <= idx_r - IDX_W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
          ready   <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          ready       <= 1'b1;
          busy        <= 1'b0;
          done        <= 1'b0;
          A_greater_B <= 1'b0;
          A_equal_B   <= 1'b0;
          A_lesser_B  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed self-checking bench for serial_mag_comparator (WIDTH=8).
module tb_serial_mag_comparator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       ready;
  logic       busy;
  logic       done;
  logic       A_greater_B;
  logic       A_equal_B;
  logic       A_lesser_B;

  int checks;
  int failures;

  serial_mag_comparator #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (A),
    .B           (B),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .A_greater_B (A_greater_B),
    .A_equal_B   (A_equal_B),
    .A_lesser_B  (A_lesser_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] flags();
    return {A_greater_B, A_equal_B, A_lesser_B};
  endfunction

  // Runs one compare; flags are {gt,eq,lt}; m is the number of SCAN cycles.
  task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int exp_m, input logic [2:0] exp_flags);
    int cyc;
    int busy_cnt;
    int flag_bad;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = ~a; B = ~b;
    cyc = 1; busy_cnt = 0; flag_bad = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      if (flags() != 3'b000) flag_bad++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_m + 1));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_m));
    chk({tag, "_scan_flags0"}, 32'(flag_bad), 32'd0);
    chk({tag, "_flags"}, {29'd0, flags()}, {29'd0, exp_flags});
    @(posedge clk); #1;
    chk({tag, "_ready_after"}, {30'd0, ready, done}, {30'd0, 1'b1, 1'b0});
    chk({tag, "_flags_held"}, {29'd0, flags()}, {29'd0, exp_flags});
  endtask

  initial begin
    int cyc;
    int done_cnt;
    int done_cyc;
    int exp_m;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [2:0] ef;
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b1; A = 8'h80; B = 8'h00;

    // Reset held with start asserted: nothing is accepted.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_status", {29'd0, ready, busy, done}, {29'd0, 3'b100});
    chk("rst_flags", {29'd0, flags()}, 32'd0);
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_idle", {29'd0, ready, busy, done}, {29'd0, 3'b100});

    run_cmp("msb_gt", 8'h80, 8'h7F, 1, 3'b100);
    run_cmp("equal", 8'hA5, 8'hA5, 8, 3'b010);
    run_cmp("lsb_lt", 8'h00, 8'h01, 8, 3'b001);
    run_cmp("lsb_gt", 8'hFF, 8'hFE, 8, 3'b100);
    run_cmp("msb_lt", 8'h40, 8'hC0, 1, 3'b001);
    run_cmp("mid_gt", 8'h3C, 8'h34, 5, 3'b100);

    // Ignored start during SCAN and the DONE cycle.
    @(negedge clk);
    A = 8'h01; B = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; done_cnt = 0; done_cyc = 0;
    while (cyc <= 14) begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      start = (cyc >= 3 && cyc <= 9);
      A = 8'h00; B = 8'hFF;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("ign_done_count", 32'(done_cnt), 32'd1);
    chk("ign_done_cycle", 32'(done_cyc), 32'd9);
    chk("ign_flags", {29'd0, flags()}, {29'd0, 3'b100});
    chk("ign_idle", {29'd0, ready, busy, done}, {29'd0, 3'b100});

    // Reset asserted in cycle 4 of an 8-cycle scan.
    @(negedge clk);
    A = 8'hA5; B = 8'hA5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_status", {29'd0, ready, busy, done}, {29'd0, 3'b100});
    chk("mid_rst_flags", {29'd0, flags()}, 32'd0);
    done_cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmp("post_rst", 8'h10, 8'h20, 3, 3'b001);

    // Random sweep against a >/==/< model and first-differing-bit latency.
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom_range(0, 255));
      exp_m = 8;
      for (int i = 7; i >= 0; i--) begin
        if (ra[i] != rb[i]) begin
          exp_m = 8 - i;
          break;
        end
      end
      ef = {ra > rb, ra == rb, ra < rb};
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_cmp("rand", ra, rb, exp_m, ef);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_mag_comparator.md
# serial_mag_comparator

Multi-bit unsigned magnitude comparator that scans two captured WIDTH-bit operands one bit per clock, MSB first, with a single 1-bit comparator cell. It stops at the first differing bit. Each operand pair is accepted with a start/ready handshake, and the block reports completion with a one-cycle done pulse plus three held result flags. It serves area-constrained datapaths where a full-width parallel compare is not wanted.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range is WIDTH ≥ 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- start  input  1  request to compare; sampled only while ready=1.
- A  input  WIDTH  operand A, unsigned; captured on the accepted start.
- B  input  WIDTH  operand B, unsigned; captured on the accepted start.
- ready  output  1  high in IDLE; the block can accept start.
- busy  output  1  high in SCAN.
- done  output  1  one-cycle pulse; the result flags are valid in this cycle.
- A_greater_B  output  1  registered result, A > B.
- A_equal_B  output  1  registered result, A == B.
- A_lesser_B  output  1  registered result, A < B.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - ready=1.
  - On start=1: load shift registers a_sh←A and b_sh←B, set idx←WIDTH-1, clear all three flags, go to SCAN.
- SCAN:
  - busy=1.
  - The cell compares a_sh[WIDTH-1] against b_sh[WIDTH-1].
  - Bits differ: latch A_greater_B / A_lesser_B from the cell, go to DONE.
  - Bits equal and idx==0: set A_equal_B=1, go to DONE.
  - Bits equal and idx≠0: shift both registers left by 1, idx←idx-1, stay in SCAN.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- Flags are mutually exclusive. Exactly one flag is high from DONE until the next accepted start. All flags are zero during SCAN.
- start is ignored in SCAN and DONE; it is not queued.
- A and B are don't-care outside the accepting cycle. Changes during SCAN have no effect.
- idx is $clog2(WIDTH) bits wide. It never wraps, because the exit at idx==0 precedes any decrement.

## Timing
- Reset values (async assert): state=IDLE, ready=1, busy=0, done=0, all three flags=0. Shift registers and idx are cleared.
- Reset deassertion is synchronized externally; the block only needs asynchronous assert.
- Reset asserted mid-SCAN or in DONE aborts the compare. No done pulse is produced, and the flags read 0.
- Latency definitions:
  - Edge 0 is the edge that accepts start.
  - i is the index of the highest bit where A and B differ.
  - m = WIDTH−i when such a bit exists; m = WIDTH when A==B.
- Cycle sequence:
  - SCAN occupies cycles 1..m.
  - done=1 in cycle m+1.
  - ready=1 again from cycle m+2.
- Latency range:
  - Best case (MSBs differ): done in cycle 2.
  - Worst case (equal, or only the LSB differs): done in cycle WIDTH+1.
- Throughput: the next start can be accepted in cycle m+2 at the earliest. Back-to-back starts are separated by at least m+2 cycles.
- A start held high continuously is accepted once per IDLE visit.

## Structure
- Package serial_cmp_pkg contains:
  - the state enum cmp_state_t {IDLE, SCAN, DONE};
  - a localparam function for the idx width, $clog2(WIDTH).
- Sub-module: exactly one instance of the existing 1-bit comparator cell `comparator`.
  - Inputs: A = a_sh[WIDTH-1], B = b_sh[WIDTH-1].
  - Its combinational outputs feed the FSM next-state and flag logic.
- No other sub-modules. The shift registers, idx counter, FSM and flag registers live in serial_mag_comparator.

## Test plan
- Reset: drive rst_n=0 with start=1 -> ready=1, busy=0, done=0, all flags 0. No acceptance until rst_n=1.
- Early exit, WIDTH=8, A=8'h80, B=8'h7F -> busy in cycle 1 only; done and A_greater_B=1 in cycle 2; ready in cycle 3.
- Full scan, WIDTH=8:
  - A=B=8'hA5 -> 8 SCAN cycles; done in cycle 9 with A_equal_B=1.
  - A=8'h00, B=8'h01 -> done in cycle 9 with A_lesser_B=1.
- Ignored start: pulse start with new operands during SCAN and in the DONE cycle -> result reflects only the first operands; exactly one done pulse.
- Reset mid-operation: assert rst_n=0 in cycle 4 of an 8-cycle scan -> outputs return to reset values immediately. A fresh compare of A=8'h10, B=8'h20 then gives done in cycle 4 with A_lesser_B=1.
- Randomized sweep: 1000 random A/B pairs with random start gaps, checked against a `>`/`==`/`<` model and the m+1 latency formula.
